// File: rtl/up_axil2lb_mslv.sv
`default_nettype none
// ============================================================================
// Module   : up_axil2lb_mslv
// Purpose  : AXI4-Lite slave to local-bus (LB) master bridge in the up_clk
//            domain. Decodes a slave index from the address and drives
//            one-hot LB selects with byte strobes. Waits for the selected
//            slave's ack, with a timeout. Returns OKAY, SLVERR or DECERR.
//            Reads and writes share one FSM, so only one access is in
//            flight at a time. Concurrent read/write requests take turns.
// Ports    : up_clk / up_rst           clock, synchronous active-high reset
//            up_axi_aw*/w*/b*          AXI-Lite write address/data/response
//            up_axi_ar*/r*             AXI-Lite read address/data
//            lb_wreq/waddr/wdata/wstrb/wsel   LB write request (1-cycle)
//            lb_rreq/raddr/rsel        LB read request (1-cycle)
//            lb_wack_slv/lb_rack_slv   per-slave ack pulses
//            lb_rdata_slv              per-slave read data, packed
//            lb_tmo                    one-cycle pulse on ack timeout
// Revision : 1.0 - initial release
// ============================================================================
module up_axil2lb_mslv #(
  parameter int LB_DATA_WDTH = 32,
  parameter int LB_ADDR_WDTH = 32,
  parameter int SLAVE_NUM    = 4,
  parameter int SLV_SEL_LSB  = 16,
  parameter int SLV_SEL_W    = 3,
  parameter int TIMEOUT_CYC  = 256
) (
  input  logic                           up_clk,
  input  logic                           up_rst,
  input  logic                           up_axi_awvalid,
  output logic                           up_axi_awready,
  input  logic [LB_ADDR_WDTH-1:0]        up_axi_awaddr,
  input  logic                           up_axi_wvalid,
  output logic                           up_axi_wready,
  input  logic [LB_DATA_WDTH-1:0]        up_axi_wdata,
  input  logic [LB_DATA_WDTH/8-1:0]      up_axi_wstrb,
  output logic                           up_axi_bvalid,
  input  logic                           up_axi_bready,
  output logic [1:0]                     up_axi_bresp,
  input  logic                           up_axi_arvalid,
  output logic                           up_axi_arready,
  input  logic [LB_ADDR_WDTH-1:0]        up_axi_araddr,
  output logic                           up_axi_rvalid,
  input  logic                           up_axi_rready,
  output logic [1:0]                     up_axi_rresp,
  output logic [LB_DATA_WDTH-1:0]        up_axi_rdata,
  output logic                           lb_wreq,
  output logic [LB_ADDR_WDTH-1:0]        lb_waddr,
  output logic [LB_DATA_WDTH-1:0]        lb_wdata,
  output logic [LB_DATA_WDTH/8-1:0]      lb_wstrb,
  output logic [SLAVE_NUM-1:0]           lb_wsel,
  output logic                           lb_rreq,
  output logic [LB_ADDR_WDTH-1:0]        lb_raddr,
  output logic [SLAVE_NUM-1:0]           lb_rsel,
  input  logic [SLAVE_NUM-1:0]           lb_wack_slv,
  input  logic [SLAVE_NUM-1:0]           lb_rack_slv,
  input  logic [LB_DATA_WDTH*SLAVE_NUM-1:0] lb_rdata_slv,
  output logic                           lb_tmo
);

  localparam int c_strb_w = LB_DATA_WDTH / 8;
  localparam int c_tmo_w  = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_resp_decerr = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_WR_RESP = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_RD_RESP = 3'd6
  } state_t;

  state_t                     r_state;
  logic                       r_rdy_en;
  logic                       r_aw_full, r_w_full, r_ar_full;
  logic [LB_ADDR_WDTH-1:0]    r_awaddr, r_araddr;
  logic [LB_DATA_WDTH-1:0]    r_wdata;
  logic [c_strb_w-1:0]        r_wstrb;
  logic                       r_last_rd;
  logic [SLAVE_NUM-1:0]       r_sel;
  logic [c_tmo_w-1:0]         r_tmo_cnt;
  logic                       r_bvalid, r_rvalid;
  logic [1:0]                 r_bresp, r_rresp;
  logic [LB_DATA_WDTH-1:0]    r_rdata;
  logic                       r_lb_wreq, r_lb_rreq, r_lb_tmo;
  logic [SLAVE_NUM-1:0]       r_lb_wsel, r_lb_rsel;
  logic [LB_ADDR_WDTH-1:0]    r_lb_waddr, r_lb_raddr;
  logic [LB_DATA_WDTH-1:0]    r_lb_wdata;
  logic [c_strb_w-1:0]        r_lb_wstrb;

  logic                       w_wr_phase, w_rd_phase;
  logic                       w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic [LB_ADDR_WDTH-1:0]    w_awaddr_eff, w_araddr_eff;
  logic [LB_DATA_WDTH-1:0]    w_wdata_eff;
  logic [c_strb_w-1:0]        w_wstrb_eff;
  logic                       w_wr_pend, w_rd_pend, w_gnt_wr, w_gnt_rd;
  logic [SLV_SEL_W-1:0]       w_widx, w_ridx;
  logic [SLAVE_NUM-1:0]       w_wsel_oh, w_rsel_oh;
  logic                       w_wack, w_rack;
  logic [LB_DATA_WDTH-1:0]    w_rdata_mux;

  assign w_wr_phase = (r_state == S_WR_REQ) || (r_state == S_WR_WAIT) || (r_state == S_WR_RESP);
  assign w_rd_phase = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) || (r_state == S_RD_RESP);

  // r_rdy_en keeps every ready low while reset is applied.
  assign up_axi_awready = r_rdy_en & ~r_aw_full & ~w_wr_phase;
  assign up_axi_wready  = r_rdy_en & ~r_w_full  & ~w_wr_phase;
  assign up_axi_arready = r_rdy_en & ~r_ar_full & ~w_rd_phase;

  assign w_aw_hs = up_axi_awvalid & up_axi_awready;
  assign w_w_hs  = up_axi_wvalid  & up_axi_wready;
  assign w_ar_hs = up_axi_arvalid & up_axi_arready;
  assign w_b_hs  = r_bvalid & up_axi_bready;
  assign w_r_hs  = r_rvalid & up_axi_rready;

  // IDLE looks through the holding registers at this cycle's handshake so
  // that the LB strobe follows the final address/data handshake by one cycle.
  assign w_awaddr_eff = r_aw_full ? r_awaddr : up_axi_awaddr;
  assign w_wdata_eff  = r_w_full  ? r_wdata  : up_axi_wdata;
  assign w_wstrb_eff  = r_w_full  ? r_wstrb  : up_axi_wstrb;
  assign w_araddr_eff = r_ar_full ? r_araddr : up_axi_araddr;

  assign w_wr_pend = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
  assign w_rd_pend = r_ar_full | w_ar_hs;

  // On conflict, the side that did not win last time is granted.
  assign w_gnt_wr = w_wr_pend & (~w_rd_pend | r_last_rd);
  assign w_gnt_rd = w_rd_pend & ~w_gnt_wr;

  assign w_widx = w_awaddr_eff[SLV_SEL_LSB +: SLV_SEL_W];
  assign w_ridx = w_araddr_eff[SLV_SEL_LSB +: SLV_SEL_W];

  // An all-zero one-hot select means the index is outside the slave range.
  genvar gi;
  generate
    for (gi = 0; gi < SLAVE_NUM; gi++) begin : g_sel_dec
      assign w_wsel_oh[gi] = (w_widx == SLV_SEL_W'(gi));
      assign w_rsel_oh[gi] = (w_ridx == SLV_SEL_W'(gi));
    end
  endgenerate

  // Only the selected slave's ack counts.
  assign w_wack = |(lb_wack_slv & r_sel);
  assign w_rack = |(lb_rack_slv & r_sel);

  always_comb begin
    w_rdata_mux = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (r_sel[i]) w_rdata_mux = w_rdata_mux | lb_rdata_slv[i*LB_DATA_WDTH +: LB_DATA_WDTH];
    end
  end

  // Holding registers: filled on handshake and freed on the response
  // handshake of their own direction.
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      r_rdy_en  <= 1'b0;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_ar_full <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_araddr  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= up_axi_awaddr;
      end else if (w_b_hs) begin
        r_aw_full <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= up_axi_wdata;
        r_wstrb  <= up_axi_wstrb;
      end else if (w_b_hs) begin
        r_w_full <= 1'b0;
      end
      if (w_ar_hs) begin
        r_ar_full <= 1'b1;
        r_araddr  <= up_axi_araddr;
      end else if (w_r_hs) begin
        r_ar_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      r_state    <= S_IDLE;
      r_last_rd  <= 1'b1;
      r_sel      <= '0;
      r_tmo_cnt  <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_rvalid   <= 1'b0;
      r_rresp    <= 2'b00;
      r_rdata    <= '0;
      r_lb_wreq  <= 1'b0;
      r_lb_rreq  <= 1'b0;
      r_lb_tmo   <= 1'b0;
      r_lb_wsel  <= '0;
      r_lb_rsel  <= '0;
      r_lb_waddr <= '0;
      r_lb_wdata <= '0;
      r_lb_wstrb <= '0;
      r_lb_raddr <= '0;
    end else begin
      r_lb_wreq <= 1'b0;
      r_lb_rreq <= 1'b0;
      r_lb_wsel <= '0;
      r_lb_rsel <= '0;
      r_lb_tmo  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_wr) begin
            r_last_rd <= 1'b0;
            if (|w_wsel_oh) begin
              r_state    <= S_WR_REQ;
              r_sel      <= w_wsel_oh;
              r_lb_wreq  <= 1'b1;
              r_lb_wsel  <= w_wsel_oh;
              r_lb_waddr <= w_awaddr_eff;
              r_lb_wdata <= w_wdata_eff;
              r_lb_wstrb <= w_wstrb_eff;
            end else begin
              r_state  <= S_WR_RESP;
              r_bvalid <= 1'b1;
              r_bresp  <= c_resp_decerr;
            end
          end else if (w_gnt_rd) begin
            r_last_rd <= 1'b1;
            if (|w_rsel_oh) begin
              r_state    <= S_RD_REQ;
              r_sel      <= w_rsel_oh;
              r_lb_rreq  <= 1'b1;
              r_lb_rsel  <= w_rsel_oh;
              r_lb_raddr <= w_araddr_eff;
            end else begin
              r_state  <= S_RD_RESP;
              r_rvalid <= 1'b1;
              r_rresp  <= c_resp_decerr;
              r_rdata  <= '0;
            end
          end
        end
        S_WR_REQ: begin
          r_state   <= S_WR_WAIT;
          r_tmo_cnt <= '0;
        end
        S_WR_WAIT: begin
          // An ack in the expiry cycle wins over the timeout.
          if (w_wack) begin
            r_state  <= S_WR_RESP;
            r_bvalid <= 1'b1;
            r_bresp  <= c_resp_okay;
          end else if (r_tmo_cnt == c_tmo_last) begin
            r_state  <= S_WR_RESP;
            r_bvalid <= 1'b1;
            r_bresp  <= c_resp_slverr;
            r_lb_tmo <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
          end
        end
        S_WR_RESP: begin
          if (up_axi_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          r_state   <= S_RD_WAIT;
          r_tmo_cnt <= '0;
        end
        S_RD_WAIT: begin
          if (w_rack) begin
            r_state  <= S_RD_RESP;
            r_rvalid <= 1'b1;
            r_rresp  <= c_resp_okay;
            r_rdata  <= w_rdata_mux;
          end else if (r_tmo_cnt == c_tmo_last) begin
            r_state  <= S_RD_RESP;
            r_rvalid <= 1'b1;
            r_rresp  <= c_resp_slverr;
            r_rdata  <= '0;
            r_lb_tmo <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
          end
        end
        S_RD_RESP: begin
          if (up_axi_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign up_axi_bvalid = r_bvalid;
  assign up_axi_bresp  = r_bresp;
  assign up_axi_rvalid = r_rvalid;
  assign up_axi_rresp  = r_rresp;
  assign up_axi_rdata  = r_rdata;
  assign lb_wreq       = r_lb_wreq;
  assign lb_waddr      = r_lb_waddr;
  assign lb_wdata      = r_lb_wdata;
  assign lb_wstrb      = r_lb_wstrb;
  assign lb_wsel       = r_lb_wsel;
  assign lb_rreq       = r_lb_rreq;
  assign lb_raddr      = r_lb_raddr;
  assign lb_rsel       = r_lb_rsel;
  assign lb_tmo        = r_lb_tmo;

endmodule
`default_nettype wire
